mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch path and the load/store path of the RISC-V core. It is a fixed-priority arbiter with a starvation guard and a request/valid handshake toward memory. It returns read data and a one-cycle ready pulse to the winning requester. It also drives a stall flag that freezes PC and pipeline registers while any request is outstanding.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits
- TIMEOUT_CYCLES, 16, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address (PC)
- if_rdata  out  DATA_WIDTH  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  load/store request; held until dm_ready
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_size  in  2  access size (00 byte, 01 half, 10 word), passed through
- dm_rdata  out  DATA_WIDTH  load data; valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for load/store
- mem_en  out  1  one-cycle issue strobe
- mem_we, mem_addr, mem_wdata, mem_size  out  1/ADDR/DATA/2  request fields, held from issue to mem_valid
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_valid  in  1  memory completion (reads and writes)
- stall  out  1  core freeze
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, arbitration:
  - Data wins when dm_req=1, unless starve_cnt==STARVE_LIMIT and if_req=1; then fetch wins.
  - Grant to the winner: latch its fields into mem_* registers, pulse mem_en next cycle, go to BUSY_IF or BUSY_DM.
- starve_cnt:
  - Increments on each data grant while if_req=1; saturates at STARVE_LIMIT.
  - Clears on any fetch grant, or when if_req=0 in IDLE.
- BUSY_x:
  - Wait for mem_valid.
  - When it arrives, register mem_rdata into x_rdata, pulse x_ready the next cycle, and return to IDLE.
  - For a fetch grant, mem_we=0 and mem_size=10.
- Request rules:
  - Dropping req before grant withdraws the request.
  - Dropping it after grant does not abort: the transaction completes and the ready pulse still fires.
- mem_valid in IDLE is ignored.
- Store completion: dm_ready pulses; dm_rdata is undefined-but-stable (holds last value).
- stall = (if_req & ~if_ready) | (dm_req & ~dm_ready).
- Reset values: state IDLE, starve_cnt 0, all outputs 0. Reset mid-transaction drops the outstanding access without a ready pulse.

## Timing
- Cycle N: req seen in IDLE. N+1: mem_en=1, state BUSY. mem_valid at cycle M≥N+1. M+1: ready=1 with data, state IDLE. M+1 is also the next arbitration cycle, so back-to-back accesses are 1 bubble apart.
- Minimum latency, req to ready: 2 cycles (mem_valid in the same cycle as mem_en).
- Simultaneous if_req and dm_req with starve_cnt<STARVE_LIMIT: data first, then fetch.
- mem_en never asserts while state≠IDLE-issue; at most one access is outstanding.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY_x.
  - On reaching TIMEOUT_CYCLES without mem_valid: pulse x_ready with x_rdata=0, set bus_err (cleared only by reset), return to IDLE.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_DM)
  - requester_t enum (REQ_IF, REQ_DM)
  - size encodings SIZE_BYTE/HALF/WORD, shared with the control unit's SizeSrc
- Sub-module arb_watchdog: timeout counter with start/clear/expire. Instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Reset, then if_req=1, if_addr=0x0000_0004, mem_valid one cycle after mem_en, mem_rdata=0x0010_0093 -> if_ready pulses at cycle 3 with if_rdata=0x0010_0093; mem_we=0, mem_size=10.
- Both requests held continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...; starve_cnt returns to 0 after the IF grant.
- Store dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_size=00 -> mem_* carry those values unchanged until mem_valid; dm_ready pulses once; stall is low the cycle after.
- rst_n=0 asserted while in BUSY_DM -> next cycle state IDLE, all outputs 0; a later mem_valid=1 produces no ready pulse.
- if_req dropped one cycle after grant -> access completes; if_ready still pulses once.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no mem_valid -> x_ready at cycle 16 after issue, rdata=0, bus_err=1 and held until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and encodings for the unified-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY_IF = ST_BUSY_IF,
        BUSY_DM = ST_BUSY_DM
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } requester_t;

    // Same encoding as the control unit's SizeSrc field
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : arb_watchdog
// Description : Busy-cycle counter; expire fires on the LIMIT-th counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expire
);
    localparam int              CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start && cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = start && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fixed-priority fetch/load-store arbiter for one memory port,
//               with starvation guard. Optional watchdog: ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [1:0]            dm_size,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  stall,
    output logic                  bus_err
);
    localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_size_q, mem_size_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  bus_err_q, bus_err_d;

    logic                  grant_valid;
    requester_t            grant_who;
    logic                  wd_expire;

    // Data has priority unless fetch has already waited STARVE_LIMIT data grants
    always_comb begin
        grant_valid = 1'b0;
        grant_who   = REQ_IF;
        if (dm_req && !(if_req && starve_cnt_q == STARVE_MAX)) begin
            grant_valid = 1'b1;
            grant_who   = REQ_DM;
        end else if (if_req) begin
            grant_valid = 1'b1;
            grant_who   = REQ_IF;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        bus_err_d    = bus_err_q;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_cnt_d = '0;
                end
                if (grant_valid) begin
                    mem_en_d = 1'b1;
                    if (grant_who == REQ_DM) begin
                        state_d     = BUSY_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_size_d  = dm_size;
                        if (if_req && starve_cnt_q != STARVE_MAX) begin
                            starve_cnt_d = starve_cnt_q + SC_W'(1);
                        end
                    end else begin
                        state_d      = BUSY_IF;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        mem_size_d   = SIZE_WORD;
                        starve_cnt_d = '0;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                // A watchdog expiry completes the access with zero data
                if (mem_valid || wd_expire) begin
                    state_d = IDLE;
                    if (!mem_valid) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == BUSY_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_valid ? mem_rdata : '0;
                    end else begin
                        dm_ready_d = 1'b1;
                        if (!mem_valid) begin
                            dm_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= 2'b00;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic wd_start;
    logic wd_clear;

    assign wd_start = (state_q != IDLE) && !mem_valid;
    assign wd_clear = (state_q == IDLE);

    arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (wd_start),
        .clear  (wd_clear),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;
    assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_valid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_size;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall, bus_err;
    logic [1:0]  mem_size;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_size   (dm_size),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = 2'b00;
        mem_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err, stall} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err, stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_basic();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h0000_0004;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_size, if_ready} !== 5'b1_0_10_0 || mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL fetch_issue: got en=%b we=%b size=%b rdy=%b addr=%h expected 1 0 10 0 00000004",
                     mem_en, mem_we, mem_size, if_ready, mem_addr);
        end
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b expected 1", stall); end
        tick();
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h4 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: got en=%b addr=%h rdy=%b expected 0 00000004 0", mem_en, mem_addr, if_ready);
        end
        mem_valid = 1'b1; mem_rdata = 32'h0010_0093;
        tick();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL fetch_ready: got rdy=%b data=%h expected 1 00100093", if_ready, if_rdata);
        end
        if_req = 1'b0; mem_valid = 1'b0;
        tick();
        checks++;
        if (if_ready !== 1'b0 || mem_en !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after: got rdy=%b en=%b stall=%b expected 0 0 0", if_ready, mem_en, stall);
        end
    endtask

    task automatic test_starvation();
        bit exp_if[10];
        bit got_if[10];
        int waits = 0;
        int n = 0;
        for (int g = 0; g < 10; g++) begin
            if (waits == SL) begin exp_if[g] = 1'b1; waits = 0; end
            else begin exp_if[g] = 1'b0; waits++; end
        end
        apply_reset();
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_addr = 32'h2000; dm_we = 1'b0; dm_size = 2'b10;
        mem_valid = 1'b1; mem_rdata = $urandom;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick();
            if (mem_en === 1'b1) begin
                got_if[n] = (mem_addr === 32'h1000);
                n++;
            end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL starve_count: got %0d grants expected 10", n); end
        for (int g = 0; g < n; g++) begin
            checks++;
            if (got_if[g] !== exp_if[g]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got fetch=%b expected fetch=%b", g, got_if[g], exp_if[g]);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) tick();
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_store();
        int c;
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_size = 2'b10;
        mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        c = 0;
        do begin tick(); c++; end while (dm_ready !== 1'b1 && c < 10);
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL load_ready: got rdy=%b data=%h expected 1 12345678", dm_ready, dm_rdata);
        end
        dm_req = 1'b0; mem_valid = 1'b0;
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_size = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({mem_we, mem_size} !== 3'b1_00 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF ||
                mem_en !== (k == 0) || dm_ready !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL store_hold[%0d]: got en=%b we=%b size=%b addr=%h wd=%h rdy=%b stall=%b expected %b 1 00 00000100 deadbeef 0 1",
                         k, mem_en, mem_we, mem_size, mem_addr, mem_wdata, dm_ready, stall, (k == 0));
            end
        end
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_ready: got rdy=%b data=%h expected 1 12345678", dm_ready, dm_rdata);
        end
        dm_req = 1'b0; mem_valid = 1'b0;
        tick();
        checks++;
        if (dm_ready !== 1'b0 || stall !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL store_after: got rdy=%b stall=%b en=%b expected 0 0 0", dm_ready, stall, mem_en);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_size = 2'b10;
        tick();
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got en=%b expected 1", mem_en); end
        rst_n = 1'b0; dm_req = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err, stall} !== 8'h00 ||
            {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_zero: got ctrl=%b addr=%h expected 00000000 0",
                     {mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err, stall}, mem_addr);
        end
        rst_n = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dm_ready !== 1'b0 || if_ready !== 1'b0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_ghost[%0d]: got dm_rdy=%b if_rdy=%b en=%b expected 0 0 0",
                         k, dm_ready, if_ready, mem_en);
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_drop_after_grant();
        int pulses = 0;
        apply_reset();
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL drop_issue: got en=%b addr=%h expected 1 00000200", mem_en, mem_addr);
        end
        if_req = 1'b0;
        tick();
        mem_valid = 1'b1; mem_rdata = 32'hA5A5_0F0F;
        for (int k = 0; k < 6; k++) begin
            tick();
            mem_valid = 1'b0;
            if (if_ready === 1'b1) begin
                pulses++;
                checks++;
                if (if_rdata !== 32'hA5A5_0F0F) begin
                    errors++;
                    $display("FAIL drop_data: got %h expected a5a50f0f", if_rdata);
                end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL drop_pulses: got %0d expected 1", pulses); end
    endtask

    // Reference model: one outstanding access, data first unless fetch has
    // watched SL data grants go by; completion shows up one cycle after mem_valid.
    task automatic test_random(input int ncycles);
        int          owner = 0;     // 0 none, 1 fetch, 2 data
        int          fetch_waits = 0;
        int          busy_cycles = 0;
        logic        e_en = 0, e_we = 0, e_ifr = 0, e_dmr = 0, e_err = 0, e_wchk = 0;
        logic [31:0] e_addr = 0, e_wdata = 0, e_ifd = 0, e_dmd = 0;
        logic [1:0]  e_size = 0;
        logic        e_stall;
        apply_reset();
        for (int c = 0; c < ncycles; c++) begin
            tick();
            checks++;
            if ({mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err} !== {e_en, e_we, e_size, e_ifr, e_dmr, e_err}) begin
                errors++;
                $display("FAIL rnd_ctrl@%0d: got en,we,size,ifr,dmr,err=%b expected %b", c,
                         {mem_en, mem_we, mem_size, if_ready, dm_ready, bus_err}, {e_en, e_we, e_size, e_ifr, e_dmr, e_err});
            end
            checks++;
            if (mem_addr !== e_addr) begin
                errors++;
                $display("FAIL rnd_addr@%0d: got %h expected %h", c, mem_addr, e_addr);
            end
            if (e_wchk) begin
                checks++;
                if (mem_wdata !== e_wdata) begin
                    errors++;
                    $display("FAIL rnd_wdata@%0d: got %h expected %h", c, mem_wdata, e_wdata);
                end
            end
            if (e_ifr) begin
                checks++;
                if (if_rdata !== e_ifd) begin
                    errors++;
                    $display("FAIL rnd_if_rdata@%0d: got %h expected %h", c, if_rdata, e_ifd);
                end
            end
            if (e_dmr) begin
                checks++;
                if (dm_rdata !== e_dmd) begin
                    errors++;
                    $display("FAIL rnd_dm_rdata@%0d: got %h expected %h", c, dm_rdata, e_dmd);
                end
            end
            // Requesters: hold until ready, occasionally withdraw, start new work at random
            if (if_req) begin
                if (e_ifr) begin if_req = ($urandom % 2) == 0; if_addr = $urandom; end
                else if ($urandom % 16 == 0) if_req = 1'b0;
            end else if ($urandom % 3 == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_req && !e_dmr) begin
                if ($urandom % 16 == 0) dm_req = 1'b0;
            end else if ($urandom % 3 == 0) begin
                dm_req = 1'b1; dm_we = ($urandom % 2) == 0; dm_addr = $urandom;
                dm_wdata = $urandom; dm_size = 2'($urandom % 4);
            end else begin
                dm_req = 1'b0;
            end
            mem_valid = ($urandom % 3) == 0;
            mem_rdata = $urandom;
            #1;
            e_stall = (if_req & ~e_ifr) | (dm_req & ~e_dmr);
            checks++;
            if (stall !== e_stall) begin
                errors++;
                $display("FAIL rnd_stall@%0d: got %b expected %b", c, stall, e_stall);
            end
            // Advance the model to the next cycle
            e_en = 1'b0; e_ifr = 1'b0; e_dmr = 1'b0;
            if (owner == 0) begin
                if (dm_req && !(if_req && fetch_waits >= SL)) begin
                    owner = 2; e_en = 1'b1; e_we = dm_we; e_addr = dm_addr;
                    e_wdata = dm_wdata; e_size = dm_size; e_wchk = 1'b1;
                    fetch_waits = if_req ? fetch_waits + 1 : 0;
                end else if (if_req) begin
                    owner = 1; e_en = 1'b1; e_we = 1'b0; e_addr = if_addr;
                    e_size = 2'b10; e_wchk = 1'b0; fetch_waits = 0;
                end else begin
                    fetch_waits = 0;
                end
                busy_cycles = 0;
            end else begin
                busy_cycles++;
`ifdef ARB_TIMEOUT_EN
                if (mem_valid || busy_cycles == TO) begin
`else
                if (mem_valid) begin
`endif
                    if (!mem_valid) e_err = 1'b1;
                    if (owner == 1) begin
                        e_ifr = 1'b1; e_ifd = mem_valid ? mem_rdata : 32'h0;
                    end else begin
                        e_dmr = 1'b1;
                        if (!mem_valid) e_dmd = 32'h0;
                        else if (!e_we) e_dmd = mem_rdata;
                    end
                    owner = 0;
                end
            end
        end
        idle_inputs();
        mem_valid = 1'b1;
        repeat (3) tick();
        mem_valid = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_size = 2'b10;
        tick();
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL to_issue: got en=%b expected 1", mem_en); end
        c = 0;
        do begin tick(); c++; end while (dm_ready !== 1'b1 && c < 40);
        checks++;
        if (c != TO || dm_rdata !== 32'h0 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL to_ready: got cycle=%0d data=%h err=%b expected %0d 0 1", c, dm_rdata, bus_err, TO);
        end
        dm_req = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus_err); end
        apply_reset();
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", bus_err); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_basic();
        test_starvation();
        test_store();
        test_reset_mid();
        test_drop_after_grant();
        test_random(3000);
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
